// File: rtl/mips_mem_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states and the latched memory request.
package mips_mem_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, FETCH, DATA} arb_state_t;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on synchronous rst.
module sat_counter #(
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CTR_W-1:0] count
);
  logic [CTR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + CTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between IF fetch and MEM data accesses (data first).
// Define MEM_ARB_PERF_EN to add the perf_if_wait / perf_dm_wait stall counters.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CTR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_pipe
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CTR_W-1:0]  perf_if_wait,
  output logic [CTR_W-1:0]  perf_dm_wait
`endif
);
  arb_state_t        state_q, state_d;
  mem_req_t          req_q, req_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
  logic              flush_q, flush_d;
  logic              dm_pend, if_pend;

  // A request still high in its own valid cycle is stale: the pipeline advances at that edge.
  assign dm_pend = dm_req & ~dm_valid_q;
  assign if_pend = if_req & ~if_valid_q;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    flush_d    = flush_q;
    unique case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        if (dm_pend) begin
          state_d     = DATA;
          req_d.we    = dm_we;
          req_d.addr  = WORD_W'(dm_addr);
          req_d.wdata = WORD_W'(dm_wdata);
        end else if (if_pend) begin
          state_d     = FETCH;
          req_d.we    = 1'b0;
          req_d.addr  = WORD_W'(if_addr);
          req_d.wdata = '0;
        end
      end
      FETCH: begin
        // A flushed fetch still finishes on the bus; only its result is thrown away.
        if (!if_req) flush_d = 1'b1;
        if (mem_ready) begin
          state_d = IDLE;
          if (if_req && !flush_q) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      DATA: begin
        if (mem_ready) begin
          state_d    = IDLE;
          dm_valid_d = 1'b1;
          if (!req_q.we) dm_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      flush_q    <= flush_d;
    end
  end

  assign mem_req    = (state_q != IDLE);
  assign mem_we     = (state_q == DATA) & req_q.we;
  assign mem_addr   = req_q.addr[ADDR_W-1:0];
  assign mem_wdata  = req_q.wdata[DATA_W-1:0];
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign if_valid   = if_valid_q;
  assign dm_valid   = dm_valid_q;
  assign stall_pipe = dm_pend;
  assign stall_if   = if_pend | dm_pend;

`ifdef MEM_ARB_PERF_EN
  sat_counter #(.CTR_W(CTR_W)) u_if_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_if & ~stall_pipe),
    .count (perf_if_wait)
  );
  sat_counter #(.CTR_W(CTR_W)) u_dm_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_pipe),
    .count (perf_dm_wait)
  );
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, random transactions against a
// transaction-level model (latency/ordering arithmetic + reference memory), and corner sequences.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_valid, dm_valid;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_if, stall_pipe;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_wait, perf_dm_wait;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_pipe(stall_pipe)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_wait(perf_if_wait), .perf_dm_wait(perf_dm_wait)
`endif
  );

  // Memory: 256 words, untouched words read back a fixed hash, mem_ready after mem_wait waits.
  function automatic logic [31:0] hash(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  logic [31:0] mem_arr [256];
  bit          written [256];
  int          mem_wait;
  int          mem_cnt;
  logic [7:0]  midx;

  assign midx      = mem_addr[9:2];
  assign mem_ready = mem_req && (mem_cnt == mem_wait);
  assign mem_rdata = !mem_ready ? 32'hBAD0_BAD0 : (written[midx] ? mem_arr[midx] : hash(int'(midx)));

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ready) mem_cnt <= 0;
    else                              mem_cnt <= mem_cnt + 1;
    if (!rst && mem_req && mem_ready && mem_we) begin
      mem_arr[midx] <= mem_wdata;
      written[midx] <= 1'b1;
    end
  end

  logic [31:0] model_mem [256];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  // One transaction group issued at cycle 0; expected latencies are cycles from issue to valid.
  task automatic run_txn(input string nm, input bit do_if, input bit do_dm, input bit we,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                         input int w, input int exp_dm, input int exp_if);
    int dm_at, if_at, dm_n, if_n, sp_n, si_n, bus_err, ncyc;
    bit in1, in2, ewe;
    logic [31:0] ea, got_dm, got_if, exp_dm_d, exp_if_d;
    @(negedge clk);
    mem_wait = w;
    if_req = do_if; if_addr = ia;
    dm_req = do_dm; dm_we = we; dm_addr = da; dm_wdata = wd;
    exp_dm_d = we ? dm_rdata : model_mem[da[9:2]];
    exp_if_d = (do_dm && we && ia[9:2] == da[9:2]) ? wd : model_mem[ia[9:2]];
    dm_at = -1; if_at = -1; dm_n = 0; if_n = 0; sp_n = 0; si_n = 0; bus_err = 0;
    got_dm = '0; got_if = '0;
    ncyc = ((exp_dm > exp_if) ? exp_dm : exp_if) + 3;
    for (int c = 0; c < ncyc; c++) begin
      #1;
      in1 = (c >= 1) && (c <= 1 + w);
      in2 = do_if && do_dm && (c >= 3 + w) && (c <= 3 + 2 * w);
      if (in1 || in2) begin
        if (in1 && do_dm) begin ewe = we; ea = da; end
        else begin ewe = 1'b0; ea = ia; end
        if (!mem_req || mem_addr !== ea || mem_we !== ewe || (ewe && mem_wdata !== wd)) bus_err++;
      end else if (mem_req || mem_we) bus_err++;
      if (stall_pipe) sp_n++;
      if (stall_if) si_n++;
      if (dm_valid) begin
        dm_n++;
        if (dm_at < 0) begin dm_at = c; got_dm = dm_rdata; end
        dm_req = 1'b0; dm_we = 1'b0;
      end
      if (if_valid) begin
        if_n++;
        if (if_at < 0) begin if_at = c; got_if = if_rdata; end
        if_req = 1'b0;
      end
      @(negedge clk);
    end
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    chk({nm, " dm_pulses"}, 32'(dm_n), 32'(do_dm));
    chk({nm, " if_pulses"}, 32'(if_n), 32'(do_if));
    if (do_dm) begin
      chk({nm, " dm_latency"}, 32'(dm_at), 32'(exp_dm));
      chk({nm, " dm_rdata"}, got_dm, exp_dm_d);
    end
    if (do_if) begin
      chk({nm, " if_latency"}, 32'(if_at), 32'(exp_if));
      chk({nm, " if_rdata"}, got_if, exp_if_d);
    end
    chk({nm, " stall_pipe_cycles"}, 32'(sp_n), do_dm ? 32'(2 + w) : 32'd0);
    chk({nm, " stall_if_cycles"}, 32'(si_n), do_if ? 32'(exp_if) : (do_dm ? 32'(2 + w) : 32'd0));
    chk({nm, " bus_errors"}, 32'(bus_err), 32'd0);
    if (do_dm && we) model_mem[da[9:2]] = wd;
  endtask

  typedef struct {
    bit          do_if, do_dm, we;
    logic [31:0] ia, da, wd;
    int          w, exp_dm, exp_if;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n_req, n_iv, last_req, n_act;
    for (int i = 0; i < 256; i++) model_mem[i] = hash(i);
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h40,  32'h0,   32'h0,         0, 0, 2};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h44,  32'h100, 32'h0,         0, 2, 4};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h200, 32'hDEAD_BEEF, 3, 5, 0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h200, 32'h0,         1, 3, 0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h300, 32'h300, 32'hCAFE_F00D, 2, 4, 8};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h3FC, 32'h0,         0, 2, 0};

    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_wait = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset if_valid", {31'd0, if_valid}, 32'd0);
    chk("reset dm_valid", {31'd0, dm_valid}, 32'd0);
    chk("reset if_rdata", if_rdata, 32'd0);
    chk("reset dm_rdata", dm_rdata, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset stalls", {30'd0, stall_if, stall_pipe}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].do_if, vecs[i].do_dm, vecs[i].we,
              vecs[i].ia, vecs[i].da, vecs[i].wd, vecs[i].w, vecs[i].exp_dm, vecs[i].exp_if);

    // Flush: drop if_req in the second wait cycle of a 3-wait fetch.
    @(negedge clk);
    mem_wait = 3; if_req = 1'b1; if_addr = 32'h80;
    n_req = 0; n_iv = 0; last_req = -1;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (c == 2) if_req = 1'b0;
      if (mem_req) begin n_req++; last_req = c; end
      if (if_valid) n_iv++;
      @(negedge clk);
    end
    chk("flush mem_req_cycles", 32'(n_req), 32'd4);
    chk("flush last_req_cycle", 32'(last_req), 32'd4);
    chk("flush if_valid_pulses", 32'(n_iv), 32'd0);
    run_txn("flush_next", 1'b1, 1'b0, 1'b0, 32'hC0, 32'h0, 32'h0, 0, 0, 2);

    // Reset in the middle of a long load.
    @(negedge clk);
    mem_wait = 5; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_mid pre mem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mid valids", {30'd0, if_valid, dm_valid}, 32'd0);
    chk("rst_mid stall_pipe follows dm_req", {31'd0, stall_pipe}, 32'd1);
    dm_req = 1'b0; rst = 1'b0;
    n_act = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (mem_req || dm_valid || if_valid || stall_pipe || stall_if) n_act++;
    end
    chk("rst_mid quiet after", 32'(n_act), 32'd0);

    for (int i = 0; i < 30; i++) begin
      int k, w;
      bit wr;
      logic [31:0] ia, da, wd;
      k  = int'($urandom_range(1, 3));
      w  = int'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      ia = 32'($urandom_range(0, 255)) << 2;
      da = 32'($urandom_range(0, 255)) << 2;
      wd = $urandom;
      run_txn($sformatf("rnd%0d", i), k[0], k[1], wr, ia, da, wd, w,
              k[1] ? 2 + w : 0, k[0] ? (k[1] ? 4 + 2 * w : 2 + w) : 0);
    end

`ifdef MEM_ARB_PERF_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("perf reset if", perf_if_wait, 32'd0);
    chk("perf reset dm", perf_dm_wait, 32'd0);
    rst = 1'b0;
    run_txn("perf_ld", 1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 3, 5, 0);
    run_txn("perf_if", 1'b1, 1'b0, 1'b0, 32'h24, 32'h0, 32'h0, 1, 0, 3);
    chk("perf_dm_wait", perf_dm_wait, 32'd5);
    chk("perf_if_wait", perf_if_wait, 32'd3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
